mem_fill_arbiter: RTL and testbench

// - Sits between the processor core's I-cache/D-cache controllers and the main memory (memory4c).
// - Arbitrates three requesters onto the single memory port: D-cache write-through, D-cache miss, I-cache miss.
// - On a miss, runs an 8-word block fill over the pipelined multi-cycle memory.
// - Streams returned words to the missing cache with a word index, then pulses done.

---
 rtl/mem_sys_pkg.sv | 28 ++
 rtl/mem_fill_arbiter_if.sv | 30 +++
 rtl/word_counter.sv | 23 ++
 rtl/mem_fill_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_fill_arbiter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_sys_pkg.sv
// rtl/mem_sys_pkg.sv - shared constants, state encoding and address helpers for the memory fill path
package mem_sys_pkg;

    localparam int ADDR_W            = 16;
    localparam int DATA_W            = 16;
    localparam int BLOCK_WORDS       = 8;
    localparam int MEM_LAT           = 4;
    localparam int WORD_IDX_W        = $clog2(BLOCK_WORDS);
    localparam int CNT_W             = WORD_IDX_W + 1;
    localparam int BLOCK_OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

    // Block-aligned base of a byte address: clear the in-block offset.
    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'((1 << BLOCK_OFFSET_BITS) - 1);
    endfunction

    // Byte offset of a word index inside a block; never reaches the tag bits.
    function automatic logic [ADDR_W-1:0] word_offset(input logic [WORD_IDX_W-1:0] idx);
        return {{(ADDR_W-WORD_IDX_W-1){1'b0}}, idx, 1'b0};
    endfunction

endpackage

// File: rtl/mem_fill_arbiter_if.sv
// rtl/mem_fill_arbiter_if.sv - memory port bundle between the fill arbiter and the main memory
interface mem_fill_arbiter_if;
    import mem_sys_pkg::*;

    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_data_valid;
    logic [DATA_W-1:0] mem_data_in;

    modport master (
        output mem_en,
        output mem_wr,
        output mem_addr,
        output mem_data_out,
        input  mem_data_valid,
        input  mem_data_in
    );

    modport slave (
        input  mem_en,
        input  mem_wr,
        input  mem_addr,
        input  mem_data_out,
        output mem_data_valid,
        output mem_data_in
    );

endinterface

// File: rtl/word_counter.sv
// rtl/word_counter.sv - small up-counter with synchronous clear used for fill issue/receive tracking
module word_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Clear wins over increment so the end-of-fill cycle always leaves zero behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mem_fill_arbiter.sv
// rtl/mem_fill_arbiter.sv - arbitrates D write-through, D miss and I miss onto one memory port and runs block fills
module mem_fill_arbiter
    import mem_sys_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  icache_miss,
    input  logic [ADDR_W-1:0]     icache_addr,
    input  logic                  dcache_miss,
    input  logic [ADDR_W-1:0]     dcache_addr,
    input  logic                  dwr_req,
    input  logic [ADDR_W-1:0]     dwr_addr,
    input  logic [DATA_W-1:0]     dwr_data,
    output logic                  dwr_ack,
    mem_fill_arbiter_if.master    mem,
    output logic                  fill_we,
    output logic                  fill_sel,
    output logic [WORD_IDX_W-1:0] fill_idx,
    output logic [DATA_W-1:0]     fill_data,
    output logic                  icache_done,
    output logic                  dcache_done,
    output logic                  busy
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  recv_cnt;

    logic              issue_inc;
    logic              recv_inc;
    logic              cnt_clr;
    logic              start_fill;
    logic              start_sel;
    logic [ADDR_W-1:0] start_addr;

    logic              mem_en_c;
    logic              mem_wr_c;
    logic [ADDR_W-1:0] mem_addr_c;

    word_counter #(.W(CNT_W)) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (issue_inc),
        .clr   (cnt_clr),
        .count (issue_cnt)
    );

    word_counter #(.W(CNT_W)) u_recv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (recv_inc),
        .clr   (cnt_clr),
        .count (recv_cnt)
    );

    // State register; reset abandons any fill in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fill target and block base are captured once at fill entry and held for the whole fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_sel <= 1'b0;
            base     <= '0;
        end else if (start_fill) begin
            fill_sel <= start_sel;
            base     <= block_base(start_addr);
        end
    end

    // Arbitration, next state and all strobes; issue and receive run independently inside FILL.
    always_comb begin
        state_next  = state;
        mem_en_c    = 1'b0;
        mem_wr_c    = 1'b0;
        mem_addr_c  = '0;
        dwr_ack     = 1'b0;
        fill_we     = 1'b0;
        icache_done = 1'b0;
        dcache_done = 1'b0;
        issue_inc   = 1'b0;
        recv_inc    = 1'b0;
        cnt_clr     = 1'b0;
        start_fill  = 1'b0;
        start_sel   = 1'b0;
        start_addr  = '0;

        unique case (state)
            ST_IDLE: begin
                if (dwr_req) begin
                    state_next = ST_WRITE;
                end else if (dcache_miss) begin
                    state_next = ST_FILL;
                    start_fill = 1'b1;
                    start_sel  = 1'b1;
                    start_addr = dcache_addr;
                end else if (icache_miss) begin
                    state_next = ST_FILL;
                    start_fill = 1'b1;
                    start_sel  = 1'b0;
                    start_addr = icache_addr;
                end
            end

            ST_WRITE: begin
                mem_en_c   = 1'b1;
                mem_wr_c   = 1'b1;
                mem_addr_c = dwr_addr;
                dwr_ack    = 1'b1;
                state_next = ST_IDLE;
            end

            ST_FILL: begin
                if (issue_cnt < CNT_W'(BLOCK_WORDS)) begin
                    mem_en_c   = 1'b1;
                    mem_addr_c = base | word_offset(issue_cnt[WORD_IDX_W-1:0]);
                    issue_inc  = 1'b1;
                end
                if (mem.mem_data_valid) begin
                    fill_we  = 1'b1;
                    recv_inc = 1'b1;
                    if (recv_cnt == CNT_W'(BLOCK_WORDS - 1)) begin
                        icache_done = ~fill_sel;
                        dcache_done = fill_sel;
                        cnt_clr     = 1'b1;
                        state_next  = ST_IDLE;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign mem.mem_en       = mem_en_c;
    assign mem.mem_wr       = mem_wr_c;
    assign mem.mem_addr     = mem_addr_c;
    assign mem.mem_data_out = dwr_data;

    assign fill_idx  = recv_cnt[WORD_IDX_W-1:0];
    assign fill_data = mem.mem_data_in;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// tb/tb_mem_fill_arbiter.sv - directed self-checking bench for mem_fill_arbiter
module tb_mem_fill_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        icache_miss = 1'b0;
    logic [15:0] icache_addr = '0;
    logic        dcache_miss = 1'b0;
    logic [15:0] dcache_addr = '0;
    logic        dwr_req = 1'b0;
    logic [15:0] dwr_addr = '0;
    logic [15:0] dwr_data = '0;
    logic        dwr_ack;
    logic        fill_we;
    logic        fill_sel;
    logic [2:0]  fill_idx;
    logic [15:0] fill_data;
    logic        icache_done;
    logic        dcache_done;
    logic        busy;

    mem_fill_arbiter_if mem_bus ();

    mem_fill_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .icache_miss (icache_miss),
        .icache_addr (icache_addr),
        .dcache_miss (dcache_miss),
        .dcache_addr (dcache_addr),
        .dwr_req     (dwr_req),
        .dwr_addr    (dwr_addr),
        .dwr_data    (dwr_data),
        .dwr_ack     (dwr_ack),
        .mem         (mem_bus),
        .fill_we     (fill_we),
        .fill_sel    (fill_sel),
        .fill_idx    (fill_idx),
        .fill_data   (fill_data),
        .icache_done (icache_done),
        .dcache_done (dcache_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Memory model: read data valid three cycles after the issue cycle, data = addr ^ 0xA5A5.
    logic [2:0]  pv = '0;
    logic [15:0] pa0 = '0, pa1 = '0, pa2 = '0;
    logic        force_valid = 1'b0;
    int          cyc = 0;

    always @(posedge clk) begin
        pv  <= {pv[1:0], mem_bus.mem_en & ~mem_bus.mem_wr};
        pa0 <= mem_bus.mem_addr;
        pa1 <= pa0;
        pa2 <= pa1;
        cyc <= cyc + 1;
    end

    assign mem_bus.mem_data_valid = pv[2] | force_valid;
    assign mem_bus.mem_data_in    = pa2 ^ 16'hA5A5;

    // Event logs filled by the monitor
    logic [15:0] iss_q[$];
    int          iss_cyc_q[$];
    logic [2:0]  idx_q[$];
    logic        sel_q[$];
    logic [15:0] fdata_q[$];
    int          order_q[$];
    int we_cnt, idone_cnt, ddone_cnt, idone_idx, ddone_idx, busy_cnt;
    int wr_cnt, ack_cnt, wr_cyc, idone_cyc, ddone_cyc, done_we_bad;
    logic [15:0] wr_addr_l, wr_data_l;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        iss_q = {}; iss_cyc_q = {}; idx_q = {}; sel_q = {}; fdata_q = {}; order_q = {};
        we_cnt = 0; idone_cnt = 0; ddone_cnt = 0; idone_idx = -1; ddone_idx = -1; busy_cnt = 0;
        wr_cnt = 0; ack_cnt = 0; wr_cyc = -1; idone_cyc = -1; ddone_cyc = -1; done_we_bad = 0;
        wr_addr_l = '0; wr_data_l = '0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_bus.mem_en && !mem_bus.mem_wr) begin
                iss_q.push_back(mem_bus.mem_addr);
                iss_cyc_q.push_back(cyc);
            end
            if (mem_bus.mem_wr) begin
                wr_cnt++;
                wr_cyc = cyc;
                wr_addr_l = mem_bus.mem_addr;
                wr_data_l = mem_bus.mem_data_out;
                order_q.push_back(2);
            end
            if (dwr_ack) ack_cnt++;
            if (fill_we) begin
                we_cnt++;
                idx_q.push_back(fill_idx);
                sel_q.push_back(fill_sel);
                fdata_q.push_back(fill_data);
            end
            if (icache_done) begin
                idone_cnt++; idone_idx = int'(fill_idx); idone_cyc = cyc; order_q.push_back(0);
                if (!fill_we) done_we_bad++;
            end
            if (dcache_done) begin
                ddone_cnt++; ddone_idx = int'(fill_idx); ddone_cyc = cyc; order_q.push_back(1);
                if (!fill_we) done_we_bad++;
            end
            if (busy) busy_cnt++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // kind: 0 fill words, 1 icache_done, 2 dcache_done, 3 dwr_ack
    task automatic wait_event(input int kind, input int target, input string tag);
        int seen;
        bit reached;
        reached = 1'b0;
        for (int n = 0; n < 60 && !reached; n++) begin
            tick();
            case (kind)
                0: seen = we_cnt;
                1: seen = idone_cnt;
                2: seen = ddone_cnt;
                default: seen = ack_cnt;
            endcase
            if (seen >= target) reached = 1'b1;
        end
        check(tag, 32'(reached), 32'd1);
    endtask

    initial begin
        clear_logs();

        // Reset state
        tick(); tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_en", 32'(mem_bus.mem_en), 0);
        check("rst_mem_wr", 32'(mem_bus.mem_wr), 0);
        check("rst_fill_we", 32'(fill_we), 0);
        check("rst_fill_sel", 32'(fill_sel), 0);
        check("rst_dwr_ack", 32'(dwr_ack), 0);
        rst_n = 1'b1;
        tick();

        // Reset mid-fill after three words
        clear_logs();
        icache_addr = 16'h0100; icache_miss = 1'b1;
        wait_event(0, 3, "t1_wait_words");
        rst_n = 1'b0;
        #1;
        check("t1_busy", 32'(busy), 0);
        check("t1_mem_en", 32'(mem_bus.mem_en), 0);
        check("t1_fill_we", 32'(fill_we), 0);
        check("t1_idone", 32'(icache_done), 0);
        check("t1_fill_sel", 32'(fill_sel), 0);
        icache_miss = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        clear_logs();
        for (int i = 0; i < 10; i++) tick();
        check("t1_no_we_after", 32'(we_cnt), 0);
        check("t1_no_idone", 32'(idone_cnt), 0);
        check("t1_idle", 32'(busy_cnt), 0);

        // I miss at 0x1236
        clear_logs();
        icache_addr = 16'h1236; icache_miss = 1'b1;
        wait_event(1, 1, "t2_wait_done");
        icache_miss = 1'b0;
        tick(); tick(); tick();
        check("t2_issue_n", 32'(iss_q.size()), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_addr%0d", i), 32'(iss_q[i]), 32'(16'h1230 + 16'(2 * i)));
            check($sformatf("t2_idx%0d", i), 32'(idx_q[i]), 32'(i));
            check($sformatf("t2_sel%0d", i), 32'(sel_q[i]), 0);
        end
        check("t2_consecutive", 32'(iss_cyc_q[7] - iss_cyc_q[0]), 7);
        check("t2_fill_cycles", 32'(busy_cnt), 11);
        check("t2_done_idx", 32'(idone_idx), 7);
        check("t2_done_latency", 32'(idone_cyc - iss_cyc_q[0]), 10);
        check("t2_done_with_we", 32'(done_we_bad), 0);
        check("t2_data7", 32'(fdata_q[7]), 32'h0000B79B);

        // Simultaneous I and D miss
        clear_logs();
        dcache_addr = 16'h2008; icache_addr = 16'h3010;
        dcache_miss = 1'b1; icache_miss = 1'b1;
        wait_event(2, 1, "t3_wait_d");
        dcache_miss = 1'b0;
        wait_event(1, 1, "t3_wait_i");
        icache_miss = 1'b0;
        tick(); tick(); tick();
        check("t3_order_n", 32'(order_q.size()), 2);
        check("t3_first_d", 32'(order_q[0]), 1);
        check("t3_second_i", 32'(order_q[1]), 0);
        check("t3_d_base", 32'(iss_q[0]), 32'h2000);
        check("t3_i_base", 32'(iss_q[8]), 32'h3010);
        check("t3_i_last", 32'(iss_q[15]), 32'h301E);
        check("t3_d_sel", 32'(sel_q[0]), 1);
        check("t3_i_sel", 32'(sel_q[8]), 0);
        check("t3_idle_gap", 32'(iss_cyc_q[8] - ddone_cyc), 2);

        // Write-through beats D miss
        clear_logs();
        dwr_addr = 16'h0040; dwr_data = 16'hBEEF; dwr_req = 1'b1;
        dcache_addr = 16'h0052; dcache_miss = 1'b1;
        wait_event(3, 1, "t4_wait_ack");
        dwr_req = 1'b0;
        wait_event(2, 1, "t4_wait_d");
        dcache_miss = 1'b0;
        tick(); tick(); tick();
        check("t4_wr_cnt", 32'(wr_cnt), 1);
        check("t4_ack_cnt", 32'(ack_cnt), 1);
        check("t4_wr_addr", 32'(wr_addr_l), 32'h0040);
        check("t4_wr_data", 32'(wr_data_l), 32'hBEEF);
        check("t4_first_write", 32'(order_q[0]), 2);
        check("t4_then_d", 32'(order_q[1]), 1);
        check("t4_d_base", 32'(iss_q[0]), 32'h0050);
        check("t4_gap", 32'(iss_cyc_q[0] - wr_cyc), 2);
        check("t4_data0", 32'(fdata_q[0]), 32'h0000A5F5);

        // Top-of-memory block, miss dropped mid-fill
        clear_logs();
        dcache_addr = 16'hFFF7; dcache_miss = 1'b1;
        wait_event(0, 2, "t5_wait_words");
        dcache_miss = 1'b0;
        wait_event(2, 1, "t5_wait_d");
        tick(); tick(); tick();
        check("t5_issue_n", 32'(iss_q.size()), 8);
        check("t5_first", 32'(iss_q[0]), 32'hFFF0);
        check("t5_last", 32'(iss_q[7]), 32'hFFFE);
        check("t5_words", 32'(we_cnt), 8);
        check("t5_ddone", 32'(ddone_cnt), 1);
        check("t5_ddone_idx", 32'(ddone_idx), 7);
        check("t5_sel", 32'(sel_q[7]), 1);

        // Spurious data valid in IDLE
        clear_logs();
        force_valid = 1'b1;
        tick(); tick();
        force_valid = 1'b0;
        tick();
        check("t6_no_we", 32'(we_cnt), 0);
        check("t6_no_done", 32'(idone_cnt + ddone_cnt), 0);
        check("t6_idle", 32'(busy_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
